// File: rtl/conv3x3_window_former_pkg.sv
// Shared widths, window geometry, FSM encoding and the padding rule for the 3x3 window former.
`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 8
`endif

package conv3x3_window_former_pkg;
    localparam int FEATURE_WIDTH = `FEATURE_WIDTH;
    localparam int DW            = FEATURE_WIDTH * 2;
    localparam int WIN_DIM       = 3;
    localparam int NUM_TAPS      = WIN_DIM * WIN_DIM;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } wf_state_t;

    // Row/column index inside the window (0 = top/left) against the frame-edge flags.
    function automatic logic tap_is_pad(input int row_i, input int col_i,
                                        input logic top, input logic bot,
                                        input logic left, input logic right);
        return (row_i == 0 && top) || (row_i == WIN_DIM - 1 && bot) ||
               (col_i == 0 && left) || (col_i == WIN_DIM - 1 && right);
    endfunction
endpackage

// File: rtl/conv3x3_window_former_line_ram.sv
// One-row line delay: simple dual-port RAM, registered read returning old data on a same-address write.
module conv_line_delay_ram
    import conv3x3_window_former_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              system_clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DW-1:0]     rd_data
);
    logic [DW-1:0] mem [2**ADDR_W];

    always_ff @(posedge system_clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/conv3x3_window_former.sv
// Forms zero-padded 3x3 windows (stride 1, pad 1) from a raster pixel stream using two line delays.
//  state | meaning
//  IDLE  | waiting for frame_start
//  RUN   | accepting pixels until the last one of the frame
//  FLUSH | issuing W+1 zero beats to push out the last windows
//  DRAIN | waiting for the window pipeline to empty
module conv3x3_window_former
    import conv3x3_window_former_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                   system_clk,
    input  logic                   rst_n,
    input  logic                   frame_start,
    input  logic [ADDR_W-1:0]      row_size,
    input  logic [ADDR_W-1:0]      col_size,
    input  logic                   in_valid,
    input  logic [DW-1:0]          in_data,
    output logic                   in_ready,
    output logic                   win_valid,
    output logic [NUM_TAPS*DW-1:0] win_data,
    output logic [ADDR_W-1:0]      win_row,
    output logic [ADDR_W-1:0]      win_col,
    output logic                   win_last,
    output logic                   busy
);
    wf_state_t state, state_nxt;

    logic [ADDR_W-1:0] w_m1, h_m1, in_c, in_r, cen_c, cen_r, addr, flush_cnt;
    logic [ADDR_W:0]   skip_cnt;
    logic              accept, beat, produce, in_last, cen_last;
    logic [DW-1:0]     beat_data;

    logic              v1, p1, last1;
    logic [DW-1:0]     d1, line1_q, line2_q;
    logic [ADDR_W-1:0] addr1, r1, c1;
    logic [DW-1:0]     win_q [WIN_DIM][WIN_DIM];

    assign in_last  = (in_c == w_m1) && (in_r == h_m1);
    assign cen_last = (cen_c == w_m1) && (cen_r == h_m1);
    assign produce  = beat && (skip_cnt == '0);
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        beat      = 1'b0;
        beat_data = in_data;
        unique case (state)
            ST_IDLE: ;
            ST_RUN: begin
                in_ready = 1'b1;
                accept   = in_valid;
                beat     = in_valid;
                if (in_valid && in_last) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                beat      = 1'b1;
                beat_data = '0;
                if (flush_cnt == '0) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (!v1) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        // A pixel presented together with frame_start is dropped.
        if (frame_start) begin
            state_nxt = ST_RUN;
            accept    = 1'b0;
            beat      = 1'b0;
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            w_m1 <= '0; h_m1 <= '0; in_c <= '0; in_r <= '0;
            cen_c <= '0; cen_r <= '0; addr <= '0; flush_cnt <= '0; skip_cnt <= '0;
        end else if (frame_start) begin
            w_m1      <= row_size - 1'b1;
            h_m1      <= col_size - 1'b1;
            in_c      <= '0;
            in_r      <= '0;
            cen_c     <= '0;
            cen_r     <= '0;
            addr      <= '0;
            flush_cnt <= '0;
            skip_cnt  <= {1'b0, row_size} + 1'b1;
        end else begin
            if (accept) begin
                if (in_c == w_m1) begin
                    in_c <= '0;
                    in_r <= in_r + 1'b1;
                end else begin
                    in_c <= in_c + 1'b1;
                end
                if (in_last) flush_cnt <= w_m1 + 1'b1;
            end else if (state == ST_FLUSH && flush_cnt != '0) begin
                flush_cnt <= flush_cnt - 1'b1;
            end
            if (beat) begin
                addr <= (addr == w_m1) ? '0 : addr + 1'b1;
                if (skip_cnt != '0) skip_cnt <= skip_cnt - 1'b1;
            end
            if (produce) begin
                if (cen_c == w_m1) begin
                    cen_c <= '0;
                    cen_r <= cen_r + 1'b1;
                end else begin
                    cen_c <= cen_c + 1'b1;
                end
            end
        end
    end

    // Both delays are read on the beat so their outputs line up with the delayed pixel one cycle later.
    conv_line_delay_ram #(.ADDR_W(ADDR_W)) u_line_r1 (
        .system_clk (system_clk),
        .wr_en      (beat),
        .wr_addr    (addr),
        .wr_data    (beat_data),
        .rd_en      (beat),
        .rd_addr    (addr),
        .rd_data    (line1_q)
    );

    conv_line_delay_ram #(.ADDR_W(ADDR_W)) u_line_r2 (
        .system_clk (system_clk),
        .wr_en      (v1),
        .wr_addr    (addr1),
        .wr_data    (line1_q),
        .rd_en      (beat),
        .rd_addr    (addr),
        .rd_data    (line2_q)
    );

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0; p1 <= 1'b0; last1 <= 1'b0; d1 <= '0;
            addr1 <= '0; r1 <= '0; c1 <= '0;
            win_valid <= 1'b0; win_last <= 1'b0; win_row <= '0; win_col <= '0;
            for (int i = 0; i < WIN_DIM; i++)
                for (int j = 0; j < WIN_DIM; j++)
                    win_q[i][j] <= '0;
        end else begin
            v1    <= beat;
            p1    <= produce;
            last1 <= cen_last;
            d1    <= beat_data;
            addr1 <= addr;
            r1    <= cen_r;
            c1    <= cen_c;
            win_valid <= p1 & ~frame_start;
            win_last  <= p1 & last1 & ~frame_start;
            if (p1) begin
                win_row <= r1;
                win_col <= c1;
            end
            if (v1) begin
                for (int i = 0; i < WIN_DIM; i++) begin
                    win_q[i][0] <= win_q[i][1];
                    win_q[i][1] <= win_q[i][2];
                end
                win_q[0][2] <= line2_q;
                win_q[1][2] <= line1_q;
                win_q[2][2] <= d1;
            end
        end
    end

    // Edge masking also hides wrap-around columns, flush zeros and stale line data.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < WIN_DIM; i++)
            for (int j = 0; j < WIN_DIM; j++)
                if (!tap_is_pad(i, j, win_row == '0, win_row == h_m1,
                                win_col == '0, win_col == w_m1))
                    win_data[(i*WIN_DIM + j)*DW +: DW] = win_q[i][j];
    end
endmodule

// File: tb/tb_conv3x3_window_former.sv
// Directed bench for conv3x3_window_former: each window is compared with a padded-image reference model.
`timescale 1ns/1ps
module tb_conv3x3_window_former;
    import conv3x3_window_former_pkg::*;

    localparam int AW = 10;
    localparam int WD = NUM_TAPS * DW;

    logic          system_clk, rst_n, frame_start, in_valid;
    logic          in_ready, win_valid, win_last, busy;
    logic [AW-1:0] row_size, col_size, win_row, win_col;
    logic [DW-1:0] in_data;
    logic [WD-1:0] win_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state
    int mW, mH, n_win, last_cyc;
    bit run_m, busy_m;
    int pix[$];
    int bcyc[$];
    logic [WD-1:0] log_data[$];
    logic          log_last[$];

    conv3x3_window_former #(.ADDR_W(AW)) dut (
        .system_clk  (system_clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .row_size    (row_size),
        .col_size    (col_size),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .win_valid   (win_valid),
        .win_data    (win_data),
        .win_row     (win_row),
        .win_col     (win_col),
        .win_last    (win_last),
        .busy        (busy)
    );

    initial system_clk = 1'b0;
    always #5 system_clk = ~system_clk;
    always @(posedge system_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_w(input string nm, input logic [WD-1:0] act, input logic [WD-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [WD-1:0] taps9(input int a0, input int a1, input int a2,
                                            input int a3, input int a4, input int a5,
                                            input int a6, input int a7, input int a8);
        int v[9];
        logic [WD-1:0] w;
        v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        w = '0;
        for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'(v[k]);
        return w;
    endfunction

    // Window centred at (r,c) read straight out of the received image, zero outside it.
    function automatic logic [WD-1:0] model_win(input int r, input int c);
        logic [WD-1:0] w;
        int rr, cc, idx;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            rr  = r + k / 3 - 1;
            cc  = c + k % 3 - 1;
            idx = rr * mW + cc;
            if (rr >= 0 && rr < mH && cc >= 0 && cc < mW && idx < pix.size())
                w[k*DW +: DW] = DW'(pix[idx]);
        end
        return w;
    endfunction

    always @(negedge system_clk) begin : compare
        int b, ecyc, tot;
        bit known, ev;
        if (!rst_n) begin
            run_m = 0; busy_m = 0; n_win = 0; mW = 1; mH = 1; last_cyc = 0;
            pix.delete(); bcyc.delete();
        end else begin
            tot = mW * mH;
            chk("in_ready", in_ready, run_m);
            chk("busy", busy, busy_m);
            known = 0; ecyc = 0;
            b = n_win + mW + 1;
            if (busy_m && n_win < tot) begin
                if (b < pix.size()) begin
                    ecyc = bcyc[b] + 2; known = 1;
                end else if (pix.size() == tot) begin
                    ecyc = last_cyc + (b - tot + 1) + 2; known = 1;
                end
            end
            ev = known && (cyc == ecyc);
            chk("win_valid", win_valid, ev);
            if (win_valid) begin
                log_data.push_back(win_data);
                log_last.push_back(win_last);
            end
            if (win_valid && ev) begin
                chk("win_row", win_row, n_win / mW);
                chk("win_col", win_col, n_win % mW);
                chk("win_last", win_last, n_win == tot - 1);
                chk_w("win_data", win_data, model_win(n_win / mW, n_win % mW));
                n_win++;
                if (n_win == tot) busy_m = 0;
            end
            if (frame_start) begin
                mW = int'(row_size); mH = int'(col_size);
                n_win = 0; run_m = 1; busy_m = 1;
                pix.delete(); bcyc.delete(); log_data.delete(); log_last.delete();
            end else if (in_valid && in_ready && run_m) begin
                pix.push_back(int'(in_data));
                bcyc.push_back(cyc);
                if (pix.size() == mW * mH) begin
                    run_m = 0; last_cyc = cyc;
                end
            end
        end
    end

    task automatic start_frame(input int w, input int h, input bit iv);
        frame_start = 1'b1;
        row_size    = AW'(w);
        col_size    = AW'(h);
        in_valid    = iv;
        in_data     = DW'(16'hBEEF);
        @(posedge system_clk); #1;
        frame_start = 1'b0;
        in_valid    = 1'b0;
    endtask

    task automatic send(input int base, input int count, input bit toggle, input bit hold_end);
        int idx, guard;
        bit ph, acc;
        idx = 0; guard = 0; ph = 1;
        while (idx < count && guard < 20000) begin
            in_valid = toggle ? ph : 1'b1;
            in_data  = DW'(base + idx);
            ph = !ph;
            @(negedge system_clk);
            acc = in_valid && in_ready;
            @(posedge system_clk); #1;
            if (acc) idx++;
            guard++;
        end
        if (idx < count) chk("send timeout", idx, count);
        in_valid = hold_end;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy && g < 8000) begin
            @(posedge system_clk); #1;
            g++;
        end
        chk("idle timeout", busy, 0);
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge system_clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; in_valid = 1'b0; in_data = '0;
        row_size = '0; col_size = '0;
        repeat (2) @(posedge system_clk);
        #1;
        chk("reset win_valid", win_valid, 0);
        chk("reset in_ready", in_ready, 0);
        chk("reset busy", busy, 0);
        chk("reset win_last", win_last, 0);
        chk_w("reset win_data", win_data, '0);
        rst_n = 1'b1;
        @(posedge system_clk); #1;

        // 4x3 frame, in_valid held
        start_frame(4, 3, 0);
        send(1, 12, 0, 0);
        wait_idle();
        chk("t1 windows", log_data.size(), 12);
        if (log_data.size() == 12) begin
            chk_w("t1 (0,0)", log_data[0], taps9(0, 0, 0, 0, 1, 2, 0, 5, 6));
            chk_w("t1 (1,1)", log_data[5], taps9(1, 2, 3, 5, 6, 7, 9, 10, 11));
            chk_w("t1 (2,3)", log_data[11], taps9(7, 8, 0, 11, 12, 0, 0, 0, 0));
            chk("t1 last flag", log_last[11], 1);
        end

        // same frame, in_valid toggling
        start_frame(4, 3, 0);
        send(1, 12, 1, 0);
        wait_idle();
        chk("t2 windows", log_data.size(), 12);
        if (log_data.size() == 12) begin
            chk_w("t2 (0,0)", log_data[0], taps9(0, 0, 0, 0, 1, 2, 0, 5, 6));
            chk_w("t2 (2,3)", log_data[11], taps9(7, 8, 0, 11, 12, 0, 0, 0, 0));
        end

        // widest row, two rows
        start_frame(1023, 2, 0);
        send(1, 2046, 0, 0);
        wait_idle();
        chk("t3 windows", log_data.size(), 2046);
        if (log_data.size() == 2046) begin
            chk_w("t3 (0,1022)", log_data[1022], taps9(0, 0, 0, 1022, 1023, 0, 2045, 2046, 0));
            chk_w("t3 (1,0)", log_data[1023], taps9(0, 1, 2, 0, 1024, 1025, 0, 0, 0));
            chk_w("t3 (1,1022)", log_data[2045], taps9(1022, 1023, 0, 2045, 2046, 0, 0, 0, 0));
        end

        // abort after 7 pixels, restart as 3x2 with a pixel offered on the pulse
        start_frame(4, 3, 0);
        send(1, 7, 0, 0);
        start_frame(3, 2, 1);
        send(101, 6, 0, 0);
        wait_idle();
        chk("t4 windows", log_data.size(), 6);
        if (log_data.size() == 6) begin
            chk_w("t4 (0,0)", log_data[0], taps9(0, 0, 0, 0, 101, 102, 0, 104, 105));
            chk_w("t4 (1,2)", log_data[5], taps9(102, 103, 0, 105, 106, 0, 0, 0, 0));
        end

        // asynchronous reset mid-frame
        start_frame(4, 3, 0);
        send(1, 8, 0, 1);
        rst_n = 1'b0;
        #1;
        chk("rst win_valid", win_valid, 0);
        chk("rst in_ready", in_ready, 0);
        chk("rst busy", busy, 0);
        chk("rst win_col", win_col, 0);
        chk("rst win_row", win_row, 0);
        chk("rst win_last", win_last, 0);
        chk_w("rst win_data", win_data, '0);
        in_valid = 1'b0;
        @(posedge system_clk); #1;
        rst_n = 1'b1;
        @(posedge system_clk); #1;
        start_frame(4, 3, 0);
        send(1, 12, 0, 0);
        wait_idle();
        chk("t5 windows", log_data.size(), 12);
        if (log_data.size() == 12)
            chk_w("t5 (1,1)", log_data[5], taps9(1, 2, 3, 5, 6, 7, 9, 10, 11));

        // in_valid held through flush and drain
        start_frame(4, 3, 0);
        send(1, 12, 0, 1);
        wait_idle();
        chk("t6 pixels taken", pix.size(), 12);
        chk("t6 windows", log_data.size(), 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
